// File: rtl/spi_ram_pkg.sv
// Shared types and helpers for the SPI RAM slave.
// Command encoding and pointer wrap arithmetic.
package spi_ram_pkg;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_e;

  function automatic int unsigned ptr_inc(
    int unsigned ptr,
    int unsigned depth
  );
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/spi_ram_burst_if.sv
// Parallel-side bus between the SPI slave and the RAM.
// Master drives commands, slave returns read data.
interface spi_ram_burst_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W+1:0] din;
  logic              rx_valid;
  logic [DATA_W-1:0] dout;
  logic              tx_valid;
  logic              err;

  modport master (
    output din, rx_valid,
    input  dout, tx_valid, err
  );

  modport slave (
    input  din, rx_valid,
    output dout, tx_valid, err
  );

endinterface

// File: rtl/spi_ram_array.sv
// Single-port synchronous RAM, 1-cycle read.
// Contents are not reset.
module spi_ram_array #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/spi_ram_burst.sv
// RAM slave with command decode, range check,
// burst pointers and 1/2-cycle read pipeline.
module spi_ram_burst
  import spi_ram_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int AUTO_INC  = 1,
  parameter int RD_LAT    = 1
) (
  input logic            clk,
  input logic            rst_n,
  spi_ram_burst_if.slave bus
);

  if (ADDR_W > DATA_W) begin : g_chk_aw
    $error("ADDR_W must not exceed DATA_W");
  end
  if (MEM_DEPTH < 2 || MEM_DEPTH > 2**ADDR_W)
  begin : g_chk_depth
    $error("MEM_DEPTH out of range");
  end
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_chk_lat
    $error("RD_LAT must be 1 or 2");
  end

  cmd_e              cmd;
  logic [DATA_W-1:0] pay;
  logic [ADDR_W-1:0] addr;
  logic              a_ok;

  assign cmd  = cmd_e'(bus.din[DATA_W+1:DATA_W]);
  assign pay  = bus.din[DATA_W-1:0];
  assign addr = pay[ADDR_W-1:0];
  assign a_ok = {1'b0, addr} < (ADDR_W+1)'(MEM_DEPTH);

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] wp_nx, rp_nx;
  logic [ADDR_W-1:0] wp_inc, rp_inc;
  logic              rd_set, rs_nx;
  logic              err_d, we, re;

  assign wp_inc = ADDR_W'(ptr_inc(32'(wr_ptr), MEM_DEPTH));
  assign rp_inc = ADDR_W'(ptr_inc(32'(rd_ptr), MEM_DEPTH));

  always_comb begin
    wp_nx = wr_ptr;
    rp_nx = rd_ptr;
    rs_nx = rd_set;
    err_d = 1'b0;
    we    = 1'b0;
    re    = 1'b0;
    if (bus.rx_valid) begin
      unique case (cmd)
        WR_ADDR: begin
          if (a_ok) wp_nx = addr;
          else      err_d = 1'b1;
        end
        WR_DATA: begin
          we = 1'b1;
          if (AUTO_INC != 0) wp_nx = wp_inc;
        end
        RD_ADDR: begin
          if (a_ok) begin
            rp_nx = addr;
            rs_nx = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        RD_DATA: begin
          re    = 1'b1;
          err_d = !rd_set;
          if (AUTO_INC != 0) rp_nx = rp_inc;
        end
        default: ;
      endcase
    end
  end

  logic [DATA_W-1:0] rdata;

  spi_ram_array #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_array (
    .clk  (clk),
    .we   (we),
    .re   (re),
    .addr (we ? wr_ptr : rd_ptr),
    .wdata(pay),
    .rdata(rdata)
  );

  logic              v1;
  logic              out_v;
  logic [DATA_W-1:0] out_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_set   <= 1'b0;
      bus.err  <= 1'b0;
      v1       <= 1'b0;
    end else begin
      wr_ptr   <= wp_nx;
      rd_ptr   <= rp_nx;
      rd_set   <= rs_nx;
      bus.err  <= err_d;
      v1       <= re;
    end
  end

  // Extra register stage between array and output for RD_LAT = 2
  if (RD_LAT == 2) begin : g_lat2
    logic              v2;
    logic [DATA_W-1:0] d2;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v2 <= 1'b0;
        d2 <= '0;
      end else begin
        v2 <= v1;
        if (v1) d2 <= rdata;
      end
    end
    assign out_v = v2;
    assign out_d = d2;
  end else begin : g_lat1
    assign out_v = v1;
    assign out_d = rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dout     <= '0;
      bus.tx_valid <= 1'b0;
    end else begin
      bus.tx_valid <= out_v;
      if (out_v) bus.dout <= out_d;
    end
  end

endmodule

// File: tb/tb_spi_ram_burst.sv
// Scoreboard bench for spi_ram_burst across three
// parameter sets sharing one clock and reset.
module tb_spi_ram_burst;
  import spi_ram_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] din = '0;
  logic       rx_valid = 1'b0;
  int         sel = 0;

  always #5 clk = ~clk;

  spi_ram_burst_if #(.DATA_W(8)) if0 ();
  spi_ram_burst_if #(.DATA_W(8)) if1 ();
  spi_ram_burst_if #(.DATA_W(8)) if2 ();

  assign if0.din = din;
  assign if1.din = din;
  assign if2.din = din;
  assign if0.rx_valid = rx_valid && sel == 0;
  assign if1.rx_valid = rx_valid && sel == 1;
  assign if2.rx_valid = rx_valid && sel == 2;

  spi_ram_burst u0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );

  spi_ram_burst #(.MEM_DEPTH(200)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  spi_ram_burst #(
    .AUTO_INC(0), .RD_LAT(2)
  ) u2 (
    .clk(clk), .rst_n(rst_n), .bus(if2)
  );

  logic       tv [3];
  logic       ev [3];
  logic [7:0] dv [3];
  assign tv[0] = if0.tx_valid;
  assign tv[1] = if1.tx_valid;
  assign tv[2] = if2.tx_valid;
  assign ev[0] = if0.err;
  assign ev[1] = if1.err;
  assign ev[2] = if2.err;
  assign dv[0] = if0.dout;
  assign dv[1] = if1.dout;
  assign dv[2] = if2.dout;

  typedef struct {
    logic [7:0] data;
    longint     due;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(string tag,
                       logic [63:0] obs,
                       logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h t=%0t",
               tag, obs, exp, $time);
    end
  endtask

  int         depth [3] = '{256, 200, 256};
  int         ainc  [3] = '{1, 1, 0};
  int         lat   [3] = '{1, 1, 2};
  int         m_wr  [3];
  int         m_rd  [3];
  bit         m_set [3];
  logic [7:0] m_last[3];
  logic [7:0] mm    [3][256];

  function automatic int qsize(int d);
    if (d == 0) return q0.size();
    if (d == 1) return q1.size();
    return q2.size();
  endfunction

  function automatic void push(int d, exp_t e);
    if (d == 0) q0.push_back(e);
    else if (d == 1) q1.push_back(e);
    else q2.push_back(e);
  endfunction

  function automatic exp_t pop(int d);
    if (d == 0) return q0.pop_front();
    if (d == 1) return q1.pop_front();
    return q2.pop_front();
  endfunction

  function automatic int wrap(int d, int p);
    return (p == depth[d] - 1) ? 0 : p + 1;
  endfunction

  task automatic send(int d, cmd_e c, int pay);
    bit   e;
    exp_t x;
    @(negedge clk);
    sel = d;
    din = {2'(c), 8'(pay)};
    rx_valid = 1'b1;
    e = 1'b0;
    case (c)
      WR_ADDR: begin
        if (pay < depth[d]) m_wr[d] = pay;
        else e = 1'b1;
      end
      WR_DATA: begin
        mm[d][m_wr[d]] = 8'(pay);
        if (ainc[d] != 0) m_wr[d] = wrap(d, m_wr[d]);
      end
      RD_ADDR: begin
        if (pay < depth[d]) begin
          m_rd[d] = pay;
          m_set[d] = 1'b1;
        end else begin
          e = 1'b1;
        end
      end
      default: begin
        e = !m_set[d];
        x.data = mm[d][m_rd[d]];
        x.due = longint'($time) + 5 + lat[d] * 10;
        push(d, x);
        if (ainc[d] != 0) m_rd[d] = wrap(d, m_rd[d]);
      end
    endcase
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    check($sformatf("err%0d_%s", d, c.name()),
          {63'b0, ev[d]}, {63'b0, e});
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    q2.delete();
    for (int d = 0; d < 3; d++) begin
      m_wr[d] = 0;
      m_rd[d] = 0;
      m_set[d] = 1'b0;
      m_last[d] = '0;
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      check("rst_dout", {56'b0, dv[d]}, 64'd0);
      check("rst_tx", {63'b0, tv[d]}, 64'd0);
      check("rst_err", {63'b0, ev[d]}, 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 3; d++) begin
      if (tv[d]) begin
        if (qsize(d) == 0) begin
          check($sformatf("tx%0d_spurious", d),
                {63'b0, tv[d]}, 64'd0);
        end else begin
          exp_t e;
          e = pop(d);
          check($sformatf("dout%0d", d),
                {56'b0, dv[d]}, {56'b0, e.data});
          check($sformatf("lat%0d", d),
                64'($time - 1), 64'(e.due));
          m_last[d] = e.data;
        end
      end else begin
        check($sformatf("hold%0d", d),
              {56'b0, dv[d]}, {56'b0, m_last[d]});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    idle(2);

    send(0, WR_ADDR, 8'h00);
    send(0, WR_DATA, 8'h3C);
    send(0, RD_DATA, 0);
    idle(3);

    send(0, WR_ADDR, 8'h10);
    send(0, WR_DATA, 8'hA1);
    send(0, WR_DATA, 8'hA2);
    send(0, WR_DATA, 8'hA3);
    send(0, RD_ADDR, 8'h10);
    for (int i = 0; i < 3; i++) send(0, RD_DATA, 0);
    idle(3);

    send(1, WR_ADDR, 199);
    send(1, WR_DATA, 8'h55);
    send(1, WR_DATA, 8'h66);
    send(1, RD_ADDR, 0);
    send(1, RD_DATA, 0);
    send(1, WR_ADDR, 5);
    send(1, WR_ADDR, 250);
    send(1, WR_DATA, 8'h99);
    send(1, RD_ADDR, 250);
    send(1, RD_ADDR, 5);
    send(1, RD_DATA, 0);
    send(1, RD_ADDR, 199);
    send(1, RD_DATA, 0);
    send(1, RD_DATA, 0);
    idle(3);

    send(2, WR_ADDR, 3);
    send(2, WR_DATA, 8'h5A);
    send(2, WR_DATA, 8'h5B);
    send(2, RD_ADDR, 3);
    send(2, RD_DATA, 0);
    send(2, RD_DATA, 0);
    idle(2);
    send(2, RD_DATA, 0);
    idle(4);

    send(0, WR_ADDR, 0);
    for (int i = 0; i < 256; i++)
      send(0, WR_DATA, (i * 37 + 11) & 8'hFF);
    for (int i = 0; i < 80; i++)
      send(0, cmd_e'($urandom_range(0, 3)),
           $urandom_range(0, 255));
    idle(4);

    send(2, RD_DATA, 0);
    do_reset();
    idle(4);
    send(2, WR_DATA, 8'h77);
    send(2, RD_DATA, 0);
    send(0, WR_DATA, 8'h42);
    send(0, RD_DATA, 0);
    idle(5);

    check("q_left", 64'(q0.size() + q1.size() + q2.size()),
          64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
